// File: rtl/text_display_ctrl.sv
// text_display_ctrl: character-cell text display with cursor, clear sweep and 2-stage pixel pipeline.
// Optional macro CURSOR_BLINK_EN blinks the cursor underline from a 64-frame counter.
module text_display_ctrl #(
    parameter int         COLS     = 80,
    parameter int         ROWS     = 30,
    parameter int         VERTICAL = 0,
    parameter logic [2:0] FG_RGB   = 3'b010,
    parameter logic [2:0] CUR_RGB  = 3'b011
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_valid,
    input  logic [6:0]  wr_char,
    output logic        wr_ready,
    input  logic        move_right,
    input  logic        move_down,
    input  logic        clr,
    output logic        clr_done,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        video_on,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_data,
    output logic [6:0]  cur_col,
    output logic [5:0]  cur_row,
    output logic [2:0]  rgb
);
    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t      state;
    logic [6:0]  clr_col;
    logic [5:0]  clr_row;
    logic [6:0]  ram [0:8191];
    logic [6:0]  char_q;
    logic [9:0]  px1, py1, px2, py2;
    logic        vo1, vo2;
    logic        idle, is_ctrl, ram_we, glyph_bit, underline, on_cursor, blink_on;
    logic [12:0] ram_waddr;
    logic [6:0]  ram_wdata, inc_col, scan_col, scan_col2;
    logic [5:0]  inc_row, scan_row, scan_row2;
    logic [3:0]  glyph_row;
    assign wr_ready  = idle;
    assign font_addr = {char_q, glyph_row};
    always_comb begin
        idle      = state == IDLE;
        is_ctrl   = wr_char == 7'h0A || wr_char == 7'h0D;
        ram_we    = ~rst & (~idle | (~clr & wr_valid & ~is_ctrl));
        ram_waddr = idle ? {cur_row, cur_col} : {clr_row, clr_col};
        ram_wdata = idle ? wr_char : 7'h20;
        inc_col   = cur_col == LAST_COL ? 7'd0 : cur_col + 7'd1;
        inc_row   = cur_row == LAST_ROW ? 6'd0 : cur_row + 6'd1;
        scan_col  = VERTICAL != 0 ? {1'b0, pixel_x[9:4]} : pixel_x[9:3];
        scan_row  = VERTICAL != 0 ? pixel_y[8:3] : {1'b0, pixel_y[8:4]};
        scan_col2 = VERTICAL != 0 ? {1'b0, px2[9:4]} : px2[9:3];
        scan_row2 = VERTICAL != 0 ? py2[8:3] : {1'b0, py2[8:4]};
        glyph_row = VERTICAL != 0 ? px1[3:0] : py1[3:0];
        glyph_bit = VERTICAL != 0 ? font_data[py2[2:0]] : font_data[~px2[2:0]];
        underline = (VERTICAL != 0 ? px2[3:1] : py2[3:1]) == 3'b111;
        // lines at y >= 512 are off-screen aliases, never the cursor cell
        on_cursor = ~py2[9] && scan_col2 == cur_col && scan_row2 == cur_row;
        rgb       = !vo2 ? 3'b000 : (underline & on_cursor & blink_on) ? CUR_RGB :
                    glyph_bit ? FG_RGB : 3'b000;
    end
`ifdef CURSOR_BLINK_EN
    logic [5:0] frame_cnt;
    assign blink_on = ~frame_cnt[5];
    always_ff @(posedge clk) begin
        if (rst) frame_cnt <= 6'd0;
        else if (px2 == 10'd0 && py2 == 10'd0) frame_cnt <= frame_cnt + 6'd1;
    end
`else
    assign blink_on = 1'b1;
`endif
    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_waddr] <= ram_wdata;
        char_q <= ram[{scan_row, scan_col}];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            {px1, py1, vo1, px2, py2, vo2} <= '0;
        end else begin
            {px1, py1, vo1} <= {pixel_x, pixel_y, video_on};
            {px2, py2, vo2} <= {px1, py1, vo1};
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cur_col  <= 7'd0;
            cur_row  <= 6'd0;
            clr_col  <= 7'd0;
            clr_row  <= 6'd0;
            clr_done <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            if (!idle) begin
                clr_col <= clr_col == LAST_COL ? 7'd0 : clr_col + 7'd1;
                if (clr_col == LAST_COL) clr_row <= clr_row + 6'd1;
                if (clr_col == LAST_COL && clr_row == LAST_ROW) begin
                    state    <= IDLE;
                    clr_done <= 1'b1;
                    cur_col  <= 7'd0;
                    cur_row  <= 6'd0;
                end
            end else if (clr) begin
                state   <= CLEAR;
                clr_col <= 7'd0;
                clr_row <= 6'd0;
            end else if (wr_valid) begin
                if (wr_char == 7'h0D) cur_col <= 7'd0;
                else if (wr_char == 7'h0A) cur_row <= inc_row;
                else begin
                    cur_col <= inc_col;
                    if (cur_col == LAST_COL) cur_row <= inc_row;
                end
            end else begin
                if (move_right) cur_col <= inc_col;
                if (move_down) cur_row <= inc_row;
            end
        end
    end
endmodule

// File: tb/tb_text_display_ctrl.sv
// tb_text_display_ctrl: directed vectors for the text display controller (horizontal 80x30 and vertical 40x60).
module tb_text_display_ctrl;
    localparam logic [2:0] FG = 3'b010;
    localparam logic [2:0] CUR = 3'b011;
    logic clk = 1'b0, rst = 1'b1;
    logic wr_valid = 0, move_right = 0, move_down = 0, clr = 0, video_on = 0;
    logic [6:0] wr_char = 0;
    logic [9:0] pixel_x = 0, pixel_y = 0;
    logic wr_ready, clr_done;
    logic [10:0] font_addr;
    logic [7:0] font_data = 0;
    logic [6:0] cur_col;
    logic [5:0] cur_row;
    logic [2:0] rgb;
    logic wr_valid_v = 0, move_right_v = 0, move_down_v = 0, clr_v = 0;
    logic wr_ready_v, clr_done_v;
    logic [10:0] font_addr_v;
    logic [7:0] font_data_v = 0;
    logic [6:0] cur_col_v;
    logic [5:0] cur_row_v;
    logic [2:0] rgb_v;
    int nvec = 0, nerr = 0;

    always #5 clk = ~clk;

    text_display_ctrl dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_char(wr_char), .wr_ready(wr_ready),
        .move_right(move_right), .move_down(move_down), .clr(clr), .clr_done(clr_done),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on), .font_addr(font_addr),
        .font_data(font_data), .cur_col(cur_col), .cur_row(cur_row), .rgb(rgb)
    );
    text_display_ctrl #(.COLS(40), .ROWS(60), .VERTICAL(1)) dut_v (
        .clk(clk), .rst(rst), .wr_valid(wr_valid_v), .wr_char(wr_char), .wr_ready(wr_ready_v),
        .move_right(move_right_v), .move_down(move_down_v), .clr(clr_v), .clr_done(clr_done_v),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on), .font_addr(font_addr_v),
        .font_data(font_data_v), .cur_col(cur_col_v), .cur_row(cur_row_v), .rgb(rgb_v)
    );

    // Font ROM: only 'A' has ink; its row pattern is 1010 followed by the glyph row number
    function automatic logic [7:0] rom(logic [10:0] a);
        return a[10:4] == 7'h41 ? {4'b1010, a[3:0]} : 8'h00;
    endfunction
    always @(posedge clk) begin
        font_data <= rom(font_addr);
        font_data_v <= rom(font_addr_v);
    end

    function automatic logic [2:0] model(bit vert, int x, int y, bit vo, logic [6:0] ch, bit cur);
        logic [9:0] xx, yy;
        logic [7:0] fd;
        xx = 10'(x);
        yy = 10'(y);
        fd = rom({ch, vert ? xx[3:0] : yy[3:0]});
        if (!vo) return 3'b000;
        if (cur && (vert ? xx[3:1] : yy[3:1]) == 3'b111) return CUR;
        return (vert ? fd[yy[2:0]] : fd[7 - xx[2:0]]) ? FG : 3'b000;
    endfunction

    typedef struct {int x; int y; bit vo; logic [2:0] e;} pix_t;
    pix_t pq[$];
    typedef struct {logic wv; logic [6:0] ch; logic mr; logic md; logic [5:0] er; logic [6:0] ec;} vec_t;
    vec_t vt[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask
    task automatic add_px(bit vert, int x, int y, bit vo, logic [6:0] ch, bit cur);
        pq.push_back('{x, y, vo, model(vert, x, y, vo, ch, cur)});
    endtask
    task automatic run_scan(bit vert, string nm);
        for (int i = 0; i <= pq.size(); i++) begin
            if (i < pq.size()) begin
                pixel_x = 10'(pq[i].x);
                pixel_y = 10'(pq[i].y);
                video_on = pq[i].vo;
            end else video_on = 1'b0;
            tick();
            if (i > 0) check(nm, vert ? rgb_v : rgb, pq[i-1].e);
        end
        pq.delete();
    endtask
    task automatic cell_chk(int r, int c, logic [6:0] ch);
        pixel_x = 10'(c * 8);
        pixel_y = 10'(r * 16);
        video_on = 1'b1;
        tick();
        video_on = 1'b0;
        check("cell", font_addr[10:4], ch);
    endtask
    task automatic goto(logic [5:0] r, logic [6:0] c);
        for (int k = 0; k < 200 && cur_row != r; k++) begin
            move_down = 1'b1;
            tick();
            move_down = 1'b0;
        end
        for (int k = 0; k < 200 && cur_col != c; k++) begin
            move_right = 1'b1;
            tick();
            move_right = 1'b0;
        end
        check("goto", {cur_row, cur_col}, {r, c});
    endtask
    task automatic wr(logic [6:0] ch);
        wr_valid = 1'b1;
        wr_char = ch;
        tick();
        wr_valid = 1'b0;
    endtask
    task automatic wait_idle();
        for (int k = 0; k < 3000 && !wr_ready; k++) tick();
        check("clr_timeout", wr_ready, 1);
    endtask

    initial begin
        int n, dc;
        vt[0] = '{1'b1, 7'h41, 1'b0, 1'b0, 6'd0, 7'd1};
        vt[1] = '{1'b0, 7'h00, 1'b1, 1'b0, 6'd0, 7'd2};
        vt[2] = '{1'b0, 7'h00, 1'b0, 1'b1, 6'd1, 7'd2};
        vt[3] = '{1'b0, 7'h00, 1'b1, 1'b1, 6'd2, 7'd3};
        vt[4] = '{1'b1, 7'h0D, 1'b0, 1'b0, 6'd2, 7'd0};
        vt[5] = '{1'b1, 7'h0A, 1'b0, 1'b0, 6'd3, 7'd0};
        vt[6] = '{1'b1, 7'h5A, 1'b1, 1'b0, 6'd3, 7'd1};
        vt[7] = '{1'b1, 7'h0A, 1'b0, 1'b1, 6'd4, 7'd1};
        vt[8] = '{1'b0, 7'h41, 1'b0, 1'b0, 6'd4, 7'd1};
        repeat (3) tick();
        check("rst_wr_ready", wr_ready, 1);
        check("rst_cursor", {cur_row, cur_col}, 0);
        check("rst_rgb", rgb, 0);
        check("rst_clr_done", clr_done, 0);
        rst = 1'b0;
        move_right = 1'b1;
        move_down = 1'b1;
        tick();
        move_right = 1'b0;
        move_down = 1'b0;
        check("both_moves", {cur_row, cur_col}, {6'd1, 7'd1});
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_busy", wr_ready, 0);
        n = 0;
        dc = 0;
        while (!wr_ready && n < 3000) begin
            n++;
            clr = (n == 1000);
            move_right = (n == 500);
            if (n == 1500) check("cur_in_clear", {cur_row, cur_col}, {6'd1, 7'd1});
            tick();
            clr = 1'b0;
            move_right = 1'b0;
            dc += int'(clr_done);
        end
        repeat (3) begin
            tick();
            dc += int'(clr_done);
        end
        check("clr_cycles", n, 2400);
        check("clr_done_pulses", dc, 1);
        check("clr_cursor", {cur_row, cur_col}, 0);
        cell_chk(0, 0, 7'h20);
        cell_chk(29, 79, 7'h20);
        cell_chk(15, 40, 7'h20);
        add_px(0, 3, 13, 1, 7'h20, 1);
        add_px(0, 3, 14, 1, 7'h20, 1);
        add_px(0, 7, 15, 1, 7'h20, 1);
        add_px(0, 11, 15, 1, 7'h20, 0);
        add_px(0, 3, 14, 0, 7'h20, 1);
        run_scan(0, "underline_h");
        for (int i = 0; i < 9; i++) begin
            wr_valid = vt[i].wv;
            wr_char = vt[i].ch;
            move_right = vt[i].mr;
            move_down = vt[i].md;
            tick();
            {wr_valid, move_right, move_down} = '0;
            check($sformatf("vec%0d", i), {cur_row, cur_col}, {vt[i].er, vt[i].ec});
        end
        cell_chk(0, 0, 7'h41);
        cell_chk(3, 0, 7'h5A);
        cell_chk(2, 3, 7'h20);
        for (int x = 0; x < 8; x++) add_px(0, x, 3, 1, 7'h41, 0);
        add_px(0, 0, 14, 1, 7'h41, 0);
        add_px(0, 5, 9, 1, 7'h41, 0);
        add_px(0, 0, 3, 0, 7'h41, 0);
        run_scan(0, "glyph_h");
        goto(6'd5, 7'd10);
        wr(7'h0D);
        check("cr", {cur_row, cur_col}, {6'd5, 7'd0});
        wr(7'h0A);
        check("lf", {cur_row, cur_col}, {6'd6, 7'd0});
        cell_chk(5, 10, 7'h20);
        cell_chk(6, 0, 7'h20);
        goto(6'd6, 7'd79);
        move_right = 1'b1;
        tick();
        move_right = 1'b0;
        check("col_wrap", {cur_row, cur_col}, {6'd6, 7'd0});
        goto(6'd29, 7'd0);
        move_down = 1'b1;
        tick();
        move_down = 1'b0;
        check("row_wrap", {cur_row, cur_col}, 0);
        goto(6'd29, 7'd79);
        wr(7'h42);
        check("wr_last_cell", {cur_row, cur_col}, 0);
        cell_chk(29, 79, 7'h42);
        goto(6'd7, 7'd79);
        wr(7'h43);
        check("wr_eol", {cur_row, cur_col}, {6'd8, 7'd0});
        cell_chk(7, 79, 7'h43);
        goto(6'd2, 7'd3);
        wr_valid = 1'b1;
        wr_char = 7'h41;
        clr = 1'b1;
        tick();
        {wr_valid, clr} = '0;
        check("clr_prio_busy", wr_ready, 0);
        check("clr_prio_cur", {cur_row, cur_col}, {6'd2, 7'd3});
        wait_idle();
        goto(6'd3, 7'd3);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (100) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_wr_ready", wr_ready, 1);
        check("abort_cursor", {cur_row, cur_col}, 0);
        dc = 0;
        repeat (2500) begin
            tick();
            dc += int'(clr_done);
        end
        check("abort_no_done", dc, 0);
        clr_v = 1'b1;
        tick();
        clr_v = 1'b0;
        n = 0;
        while (!wr_ready_v && n < 3000) begin
            tick();
            n++;
        end
        check("v_clr_cycles", n, 2400);
        check("v_clr_done", clr_done_v, 1);
        wr_valid_v = 1'b1;
        wr_char = 7'h41;
        tick();
        wr_valid_v = 1'b0;
        check("v_wr", {cur_row_v, cur_col_v}, {6'd0, 7'd1});
        for (int y = 0; y < 8; y++) add_px(1, 3, y, 1, 7'h41, 0);
        add_px(1, 30, 2, 1, 7'h20, 1);
        add_px(1, 28, 2, 1, 7'h20, 1);
        add_px(1, 30, 10, 1, 7'h20, 0);
        run_scan(1, "glyph_v");
        repeat (59) begin
            move_down_v = 1'b1;
            tick();
            move_down_v = 1'b0;
        end
        repeat (38) begin
            move_right_v = 1'b1;
            tick();
            move_right_v = 1'b0;
        end
        check("v_corner", {cur_row_v, cur_col_v}, {6'd59, 7'd39});
        {move_right_v, move_down_v} = 2'b11;
        tick();
        {move_right_v, move_down_v} = 2'b00;
        check("v_both_wrap", {cur_row_v, cur_col_v}, 0);
        add_px(1, 14, 3, 1, 7'h41, 1);
        add_px(1, 12, 0, 1, 7'h41, 1);
        add_px(1, 12, 1, 1, 7'h41, 1);
        add_px(1, 12, 2, 1, 7'h41, 1);
        run_scan(1, "underline_v");
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/text_display_ctrl.md
TEXT_DISPLAY_CTRL -- requirements
Module: text_display_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 80, text columns (1..80 horizontal, 1..40 vertical).
REQ-002 SHALL have parameter ROWS, default 30, text rows (1..30 horizontal, 1..60 vertical).
REQ-003 SHALL have parameter VERTICAL, default 0; 0 = upright 8x16 cells, 1 = 90-degree-rotated 16x8 cells.
REQ-004 SHALL have parameters FG_RGB, default 3'b010, glyph colour; CUR_RGB, default 3'b011, cursor underline colour.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 wr_valid  input  1  character write request.
REQ-008 wr_char  input  7  ASCII code to write.
REQ-009 wr_ready  output  1  write accepted when wr_valid & wr_ready.
REQ-010 move_right, move_down  input  1 each  single-cycle cursor-move ticks.
REQ-011 clr  input  1  single-cycle clear-screen request.
REQ-012 clr_done  output  1  one-cycle pulse at end of clear.
REQ-013 pixel_x, pixel_y  input  10 each  current scan position; video_on  input  1.
REQ-014 font_addr  output  11  {char[6:0], glyph_row[3:0]} to external font ROM; font_data  input  8, valid 1 cycle after font_addr.
REQ-015 cur_col  output  7, cur_row  output  6  cursor position; rgb  output  3  pixel colour.

Function
REQ-016 Internal char RAM SHALL be addressed {row[5:0], col[6:0]}; write port = cursor, read port = scan cell; read data 1 cycle after address.
REQ-017 Horizontal: scan col = pixel_x[9:3], row = pixel_y[8:4], glyph_row = pixel_y[3:0], bit = font_data[7 - x[2:0]], underline when y[3:1] = 3'b111.
REQ-018 Vertical: scan col = pixel_x[9:4], row = pixel_y[8:3], glyph_row = pixel_x[3:0], bit = font_data[y[2:0]], underline when x[3:1] = 3'b111.
REQ-019 pixel_x, pixel_y, video_on SHALL be delayed 2 cycles; rgb for an input pixel SHALL appear 2 cycles after it; glyph_row/bit selection uses the matching delay stage.
REQ-020 rgb priority: !video_on -> 0; else underline on cursor cell -> CUR_RGB; else glyph bit ? FG_RGB : 0.
REQ-021 FSM states IDLE, CLEAR; IDLE -> CLEAR on clr; CLEAR -> IDLE after last cell; clr in CLEAR ignored.
REQ-022 CLEAR SHALL write 7'h20 to every cell row 0..ROWS-1, col 0..COLS-1, one per cycle (ROWS*COLS cycles), then pulse clr_done and set cursor (0,0).
REQ-023 wr_ready SHALL be 1 in IDLE, 0 in CLEAR; move ticks ignored in CLEAR.
REQ-024 Accepted printable char (not 0x0A/0x0D) SHALL be written at cursor, then col+1; col = COLS-1 wraps to 0 with row+1; row = ROWS-1 wraps to 0.
REQ-025 0x0D SHALL set col 0, no RAM write; 0x0A SHALL advance row (wrap to 0), col unchanged, no RAM write.
REQ-026 move_right: col+1 wrapping to 0 without row change; move_down: row+1 wrapping to 0; both together apply both.
REQ-027 Same-cycle accepted write and move ticks: write advance applies, ticks dropped; clr in IDLE takes priority over write and ticks (write not accepted).

Reset
REQ-028 rst SHALL force IDLE, cursor (0,0), rgb 0, clr_done 0, delay pipelines 0, wr_ready 1 next cycle; RAM contents not cleared.
REQ-029 rst during CLEAR SHALL abort the sweep without clr_done.

Configuration
REQ-030 Macro CURSOR_BLINK_EN defined: 6-bit frame counter increments when delayed pixel_x = 0 and pixel_y = 0; underline shown only when counter[5] = 0; counter reset to 0.
REQ-031 Macro undefined: underline always shown, no frame counter.

Verification
REQ-032 Reset, write 'A'(0x41) -> cell (0,0)=0x41, cursor (0,1), rgb=FG_RGB on glyph pixels 2 cycles later.
REQ-033 COLS=80, ROWS=30, cursor (29,79), write 0x42 -> cell (29,79)=0x42, cursor (0,0).
REQ-034 Write 0x0D then 0x0A from (5,10) -> cursor (6,0), no cell changed.
REQ-035 clr pulse -> wr_ready 0 for 2400 cycles, all cells 0x20, clr_done one pulse, cursor (0,0); second clr mid-sweep ignored.
REQ-036 VERTICAL=1, cursor (59,39), move_right & move_down same cycle -> cursor (0,0); underline at x[3:1]=7 in cell.
REQ-037 CURSOR_BLINK_EN defined: underline visible frames 0-31, hidden frames 32-63.
